// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched
// Write-back scheduler and pending-write scoreboard for the 32x32 register
// file. Two write-back sources (A: ALU/branch-link, B: load/mul-div) share
// the single register file write port through a round-robin arbiter. A
// per-register pending-write counter lets the issue stage spot RAW/WAW
// hazards.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   iss_valid/iss_rd     reserve a destination register for a future write
//   iss_ready            reservation accepted (0 only when counter saturated)
//   q_addr1/q_busy1      hazard query 1: register has a pending write
//   q_addr2/q_busy2      hazard query 2
//   a_valid/a_addr/a_data/a_ready   source A write-back handshake
//   b_valid/b_addr/b_data/b_ready   source B write-back handshake
//   wen/waddr/wdata      registered register file write port
module regfile_wb_sched #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32,
  parameter int CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  output logic                  iss_ready,
  input  logic [REG_ADDR_W-1:0] q_addr1,
  output logic                  q_busy1,
  input  logic [REG_ADDR_W-1:0] q_addr2,
  output logic                  q_busy2,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0]     a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0]     b_data,
  output logic                  b_ready,
  output logic                  wen,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0]     wdata
);

  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  logic [CNT_W-1:0]      cnt [NUM_REGS];
  logic                  last_b;
  logic                  xfer;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_data;
  logic [NUM_REGS-1:0]   inc;
  logic [NUM_REGS-1:0]   dec;

  // Round-robin grant: an uncontested requester always wins; under
  // contention the source that did not win last time gets the port, so the
  // loser never waits more than one cycle. The two readies are mutually
  // exclusive by construction.
  always_comb begin
    a_ready  = a_valid && (!b_valid || last_b);
    b_ready  = b_valid && (!a_valid || !last_b);
    xfer     = a_ready || b_ready;
    sel_addr = a_ready ? a_addr : b_addr;
    sel_data = a_ready ? a_data : b_data;
  end

  // Reservation and hazard queries read the scoreboard combinationally.
  // Register 0 is never busy and reservations on it are always accepted.
  always_comb begin
    iss_ready = !((cnt[iss_rd] == CNT_SAT) && (iss_rd != '0));
    q_busy1   = (q_addr1 != '0) && (cnt[q_addr1] != '0);
    q_busy2   = (q_addr2 != '0) && (cnt[q_addr2] != '0);
  end

  // Per-register increment (accepted reservation) and decrement (the write
  // actually reaching the register file). Decrementing on wen rather than on
  // the transfer keeps busy asserted through the wen cycle.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc[r] = iss_valid && iss_ready && (iss_rd == REG_ADDR_W'(r));
      dec[r] = wen && (waddr == REG_ADDR_W'(r));
    end
  end

  // Arbiter pointer and registered write port. Reset starts the pointer at
  // "last granted = B" so A wins the first contention, and drops any write
  // accepted in the reset cycle. A transfer to register 0 is consumed but
  // never enables the register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_b <= 1'b1;
      wen    <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
    end else begin
      wen <= xfer && (sel_addr != '0);
      if (xfer) begin
        last_b <= b_ready;
        waddr  <= sel_addr;
        wdata  <= sel_data;
      end
    end
  end

  // Pending-write counters. Simultaneous inc and dec cancel; a decrement of
  // an empty counter (write without reservation) holds at zero. Saturation
  // needs no guard because iss_ready blocks the increment there.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (r == 0)
          cnt[r] <= '0;
        else if (inc[r] && !dec[r])
          cnt[r] <= cnt[r] + CNT_W'(1);
        else if (dec[r] && !inc[r] && (cnt[r] != '0))
          cnt[r] <= cnt[r] - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched
// Directed bench for regfile_wb_sched. Inputs are driven 1 time unit after
// each rising edge and outputs are sampled 1 unit later, well away from the
// active edge. Every expected value below is worked out by hand from the
// intended cycle-by-cycle behaviour.
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  q_addr1;
  logic        q_busy1;
  logic [4:0]  q_addr2;
  logic        q_busy2;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int checks = 0;
  int errors = 0;

  regfile_wb_sched dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .q_addr1(q_addr1), .q_busy1(q_busy1),
    .q_addr2(q_addr2), .q_busy2(q_busy2),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .wen(wen), .waddr(waddr), .wdata(wdata)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Drive one cycle's worth of request inputs, then let combinational
  // outputs settle before anything is sampled.
  task automatic applyStimulus(input logic iv, input logic [4:0] ird,
                               input logic av, input logic [4:0] aa, input logic [31:0] ad,
                               input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    iss_valid = iv;  iss_rd = ird;
    a_valid   = av;  a_addr = aa;  a_data = ad;
    b_valid   = bv;  b_addr = ba;  b_data = bd;
    #1;
  endtask

  // One comparison: count it, and on a miss count the error and report it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence, one block of steps per scenario.
  initial begin
    reset = 1'b1;
    q_addr1 = '0;
    q_addr2 = '0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    nextCycle();
    reset = 1'b0;
    #1;

    // Reset then idle.
    checkOutput("rst_wen", 32'(wen), 0);
    checkOutput("rst_waddr", 32'(waddr), 0);
    checkOutput("rst_wdata", wdata, 0);
    checkOutput("rst_a_ready", 32'(a_ready), 0);
    checkOutput("rst_b_ready", 32'(b_ready), 0);
    for (int i = 0; i < 32; i++) begin
      q_addr1 = 5'(i);
      #1;
      checkOutput($sformatf("rst_busy_%0d", i), 32'(q_busy1), 0);
    end
    nextCycle();

    // Reserve r5, write it from A, watch busy span the wen cycle.
    q_addr1 = 5'd5;
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 0);
    checkOutput("r5_iss_ready", 32'(iss_ready), 1);
    checkOutput("r5_busy_c1", 32'(q_busy1), 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r5_busy_c2", 32'(q_busy1), 1);
    nextCycle();
    applyStimulus(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    checkOutput("r5_a_ready", 32'(a_ready), 1);
    checkOutput("r5_b_ready", 32'(b_ready), 0);
    checkOutput("r5_busy_c3", 32'(q_busy1), 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r5_wen", 32'(wen), 1);
    checkOutput("r5_waddr", 32'(waddr), 5);
    checkOutput("r5_wdata", wdata, 32'hDEADBEEF);
    checkOutput("r5_busy_c4", 32'(q_busy1), 1);
    nextCycle();
    checkOutput("r5_busy_c5", 32'(q_busy1), 0);
    checkOutput("r5_wen_off", 32'(wen), 0);
    checkOutput("r5_waddr_hold", 32'(waddr), 5);
    checkOutput("r5_wdata_hold", wdata, 32'hDEADBEEF);

    // Lone B write (moves the pointer to B), then sustained contention.
    q_addr1 = 5'd1;
    q_addr2 = 5'd2;
    applyStimulus(0, 0, 0, 0, 0, 1, 2, 32'h22);
    checkOutput("rr_c0_b_ready", 32'(b_ready), 1);
    checkOutput("rr_c0_a_ready", 32'(a_ready), 0);
    nextCycle();
    applyStimulus(0, 0, 1, 1, 32'h11, 1, 2, 32'h22);
    checkOutput("rr_c1_a_ready", 32'(a_ready), 1);
    checkOutput("rr_c1_b_ready", 32'(b_ready), 0);
    checkOutput("rr_c1_wen", 32'(wen), 1);
    checkOutput("rr_c1_waddr", 32'(waddr), 2);
    checkOutput("rr_c1_wdata", wdata, 32'h22);
    nextCycle();
    checkOutput("rr_c2_a_ready", 32'(a_ready), 0);
    checkOutput("rr_c2_b_ready", 32'(b_ready), 1);
    checkOutput("rr_c2_waddr", 32'(waddr), 1);
    checkOutput("rr_c2_wdata", wdata, 32'h11);
    nextCycle();
    checkOutput("rr_c3_a_ready", 32'(a_ready), 1);
    checkOutput("rr_c3_b_ready", 32'(b_ready), 0);
    checkOutput("rr_c3_wen", 32'(wen), 1);
    checkOutput("rr_c3_waddr", 32'(waddr), 2);
    nextCycle();
    checkOutput("rr_c4_a_ready", 32'(a_ready), 0);
    checkOutput("rr_c4_b_ready", 32'(b_ready), 1);
    checkOutput("rr_c4_wen", 32'(wen), 1);
    checkOutput("rr_c4_waddr", 32'(waddr), 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rr_c5_wen", 32'(wen), 1);
    checkOutput("rr_c5_waddr", 32'(waddr), 2);
    checkOutput("rr_c5_busy2", 32'(q_busy2), 0);
    checkOutput("rr_c5_busy1", 32'(q_busy1), 0);
    nextCycle();
    checkOutput("rr_c6_wen", 32'(wen), 0);
    checkOutput("rr_c6_no_underflow", 32'(q_busy2), 0);

    // Saturate r7, then drain it with three writes.
    q_addr1 = 5'd7;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 7, 0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("sat_iss_ready_%0d", k), 32'(iss_ready), 1);
      nextCycle();
    end
    applyStimulus(1, 7, 0, 0, 0, 0, 0, 0);
    checkOutput("sat_iss_ready_full", 32'(iss_ready), 0);
    checkOutput("sat_busy_full", 32'(q_busy1), 1);
    nextCycle();
    applyStimulus(0, 7, 1, 7, 32'h77, 0, 0, 0);
    checkOutput("sat_w1_a_ready", 32'(a_ready), 1);
    checkOutput("sat_still_full", 32'(iss_ready), 0);
    nextCycle();
    applyStimulus(0, 7, 0, 0, 0, 0, 0, 0);
    checkOutput("sat_w1_wen", 32'(wen), 1);
    checkOutput("sat_w1_waddr", 32'(waddr), 7);
    checkOutput("sat_full_in_wen", 32'(iss_ready), 0);
    nextCycle();
    applyStimulus(0, 7, 1, 7, 32'h78, 0, 0, 0);
    checkOutput("sat_ready_again", 32'(iss_ready), 1);
    checkOutput("sat_busy_2left", 32'(q_busy1), 1);
    checkOutput("sat_w2_a_ready", 32'(a_ready), 1);
    nextCycle();
    applyStimulus(0, 7, 1, 7, 32'h79, 0, 0, 0);
    checkOutput("sat_w3_a_ready", 32'(a_ready), 1);
    checkOutput("sat_w2_wdata", wdata, 32'h78);
    checkOutput("sat_busy_w3", 32'(q_busy1), 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("sat_w3_wdata", wdata, 32'h79);
    checkOutput("sat_busy_last_wen", 32'(q_busy1), 1);
    nextCycle();
    checkOutput("sat_busy_clear", 32'(q_busy1), 0);

    // Reserve and write-back to r9 in the same cycle cancel out.
    q_addr1 = 5'd9;
    applyStimulus(1, 9, 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 1, 9, 32'h99, 0, 0, 0);
    checkOutput("r9_a_ready", 32'(a_ready), 1);
    nextCycle();
    applyStimulus(1, 9, 0, 0, 0, 0, 0, 0);
    checkOutput("r9_wen", 32'(wen), 1);
    checkOutput("r9_waddr", 32'(waddr), 9);
    checkOutput("r9_iss_ready", 32'(iss_ready), 1);
    nextCycle();
    applyStimulus(0, 0, 1, 9, 32'h9A, 0, 0, 0);
    checkOutput("r9_busy_after_both", 32'(q_busy1), 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r9_busy_wen", 32'(q_busy1), 1);
    nextCycle();
    checkOutput("r9_busy_clear", 32'(q_busy1), 0);

    // Writes and reservations aimed at register 0.
    q_addr1 = 5'd0;
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h55);
    checkOutput("r0_b_ready", 32'(b_ready), 1);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r0_wen", 32'(wen), 0);
    checkOutput("r0_iss_ready", 32'(iss_ready), 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r0_busy", 32'(q_busy1), 0);

    // Reservations plus a write in flight, then a one-cycle reset.
    q_addr1 = 5'd3;
    q_addr2 = 5'd4;
    applyStimulus(1, 3, 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 4, 1, 10, 32'hA0, 0, 0, 0);
    checkOutput("rs_a_ready", 32'(a_ready), 1);
    checkOutput("rs_busy3_pre", 32'(q_busy1), 1);
    nextCycle();
    reset = 1'b1;
    applyStimulus(0, 0, 1, 11, 32'hB0, 0, 0, 0);
    checkOutput("rs_busy4_pre", 32'(q_busy2), 1);
    checkOutput("rs_wen_pre", 32'(wen), 1);
    checkOutput("rs_waddr_pre", 32'(waddr), 10);
    nextCycle();
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rs_wen_dropped", 32'(wen), 0);
    checkOutput("rs_waddr_clr", 32'(waddr), 0);
    checkOutput("rs_wdata_clr", wdata, 0);
    checkOutput("rs_busy3", 32'(q_busy1), 0);
    checkOutput("rs_busy4", 32'(q_busy2), 0);
    nextCycle();
    applyStimulus(0, 0, 1, 12, 32'hC0, 1, 13, 32'hD0);
    checkOutput("rs_a_wins", 32'(a_ready), 1);
    checkOutput("rs_b_loses", 32'(b_ready), 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rs_post_wen", 32'(wen), 1);
    checkOutput("rs_post_waddr", 32'(waddr), 12);
    checkOutput("rs_post_wdata", wdata, 32'hC0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
